// File: rtl/ex_operand_stage.sv
// ID/EX boundary register: operand resolution, forwarding, load-use bubbles.
// Define EX_OPERAND_FWD_EN to enable EX/MEM/WB forwarding; otherwise dependent instructions stall.
module ex_operand_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_src1_pc,
  input  logic              id_src2_imm,
  input  logic [4:0]        id_funct_select,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic [XLEN-1:0]   ex_result,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_result,
  input  logic              wb_valid,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_result,
  input  logic              stall_in,
  input  logic              flush,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_is_load,
  output logic [REG_AW-1:0] ex_rd,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   alu_in1,
  output logic [XLEN-1:0]   alu_in2,
  output logic [4:0]        funct_select,
  output logic [XLEN-1:0]   ex_store_data
);

  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic            ex_wr_ok;
  logic            mem_wr_ok;
  logic            wb_wr_ok;

  // A writer at rd hits the decoding instruction if rd is nonzero and matches a used source.
  function automatic logic rd_hit(input logic wr, input logic [REG_AW-1:0] rd,
                                  input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                                  input logic u1, input logic u2);
    return wr && (rd != '0) && ((u1 && (rd == rs1)) || (u2 && (rd == rs2)));
  endfunction

  assign mem_wr_ok = mem_valid && mem_reg_write;
  assign wb_wr_ok  = wb_valid && wb_reg_write;

`ifdef EX_OPERAND_FWD_EN
  // Loads have no result yet in EX, so they are excluded from EX forwarding.
  assign ex_wr_ok = ex_valid && ex_reg_write && !ex_is_load;

  always_comb begin
    fwd_rs1 = id_rs1_data;
    if (id_rs1 == '0)                           fwd_rs1 = '0;
    else if (ex_wr_ok  && (ex_rd  == id_rs1))   fwd_rs1 = ex_result;
    else if (mem_wr_ok && (mem_rd == id_rs1))   fwd_rs1 = mem_result;
    else if (wb_wr_ok  && (wb_rd  == id_rs1))   fwd_rs1 = wb_result;
  end

  always_comb begin
    fwd_rs2 = id_rs2_data;
    if (id_rs2 == '0)                           fwd_rs2 = '0;
    else if (ex_wr_ok  && (ex_rd  == id_rs2))   fwd_rs2 = ex_result;
    else if (mem_wr_ok && (mem_rd == id_rs2))   fwd_rs2 = mem_result;
    else if (wb_wr_ok  && (wb_rd  == id_rs2))   fwd_rs2 = wb_result;
  end

  assign hazard_stall = id_valid &&
                        rd_hit(ex_valid && ex_is_load, ex_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2);
`else
  logic fwd_unused;

  assign ex_wr_ok   = ex_valid && ex_reg_write;
  assign fwd_unused = ^{ex_result, mem_result, wb_result};

  assign fwd_rs1 = (id_rs1 == '0) ? '0 : id_rs1_data;
  assign fwd_rs2 = (id_rs2 == '0) ? '0 : id_rs2_data;

  // Without forwarding, hold ID until every in-flight writer of a source has retired.
  assign hazard_stall = id_valid &&
                        (rd_hit(ex_wr_ok,  ex_rd,  id_rs1, id_rs2, id_use_rs1, id_use_rs2) ||
                         rd_hit(mem_wr_ok, mem_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2) ||
                         rd_hit(wb_wr_ok,  wb_rd,  id_rs1, id_rs2, id_use_rs1, id_use_rs2));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_is_load    <= 1'b0;
      ex_rd         <= '0;
      ex_pc         <= '0;
      alu_in1       <= '0;
      alu_in2       <= '0;
      funct_select  <= '0;
      ex_store_data <= '0;
    end else if (!stall_in) begin
      if (flush || hazard_stall) begin
        ex_valid      <= 1'b0;
        ex_reg_write  <= 1'b0;
        ex_is_load    <= 1'b0;
        ex_rd         <= '0;
        ex_pc         <= '0;
        alu_in1       <= '0;
        alu_in2       <= '0;
        funct_select  <= '0;
        ex_store_data <= '0;
      end else begin
        ex_valid      <= id_valid;
        ex_reg_write  <= id_reg_write;
        ex_is_load    <= id_is_load;
        ex_rd         <= id_rd;
        ex_pc         <= id_pc;
        alu_in1       <= id_src1_pc ? id_pc : fwd_rs1;
        alu_in2       <= id_src2_imm ? id_imm : fwd_rs2;
        funct_select  <= id_funct_select;
        ex_store_data <= fwd_rs2;
      end
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage; expectations follow EX_OPERAND_FWD_EN when defined.
module tb_ex_operand_stage;

  typedef struct packed {
    logic        v;
    logic        rw;
    logic        ld;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [4:0]  fs;
    logic [31:0] sd;
  } out_t;

  typedef struct packed {
    logic h;
    out_t o;
  } rec_t;

  localparam out_t BUB = '0;

  logic        clk = 1'b1;
  logic        rst;
  logic        id_valid, id_use_rs1, id_use_rs2, id_src1_pc, id_src2_imm;
  logic        id_reg_write, id_is_load;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd, id_funct_select;
  logic [31:0] ex_result, mem_result, wb_result;
  logic        mem_valid, mem_reg_write, wb_valid, wb_reg_write;
  logic [4:0]  mem_rd, wb_rd;
  logic        stall_in, flush;
  logic        hazard_stall, ex_valid, ex_reg_write, ex_is_load;
  logic [4:0]  ex_rd, funct_select;
  logic [31:0] ex_pc, alu_in1, alu_in2, ex_store_data;

  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ex_operand_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_src1_pc(id_src1_pc), .id_src2_imm(id_src2_imm), .id_funct_select(id_funct_select),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .ex_result(ex_result),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .stall_in(stall_in), .flush(flush), .hazard_stall(hazard_stall),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .ex_pc(ex_pc), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .funct_select(funct_select), .ex_store_data(ex_store_data)
  );

  function automatic out_t mk(input logic v, input logic rw, input logic ld, input logic [4:0] rd,
                              input logic [31:0] pc, input logic [31:0] a1, input logic [31:0] a2,
                              input logic [4:0] fs, input logic [31:0] sd);
    out_t o;
    o.v = v; o.rw = rw; o.ld = ld; o.rd = rd; o.pc = pc;
    o.a1 = a1; o.a2 = a2; o.fs = fs; o.sd = sd;
    return o;
  endfunction

  task automatic idle();
    id_valid = 1'b0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    id_src1_pc = 1'b0; id_src2_imm = 1'b0; id_funct_select = '0;
    id_reg_write = 1'b0; id_is_load = 1'b0;
    ex_result = '0;
    mem_valid = 1'b0; mem_reg_write = 1'b0; mem_rd = '0; mem_result = '0;
    wb_valid = 1'b0; wb_reg_write = 1'b0; wb_rd = '0; wb_result = '0;
    stall_in = 1'b0; flush = 1'b0;
  endtask

  task automatic set_id(input logic [31:0] pc, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic u1, input logic [31:0] d1,
                        input logic [4:0] rs2, input logic u2, input logic [31:0] d2,
                        input logic [31:0] imm, input logic s1pc, input logic s2imm,
                        input logic [4:0] fs, input logic rw, input logic ld);
    id_valid = 1'b1; id_pc = pc; id_rd = rd;
    id_rs1 = rs1; id_use_rs1 = u1; id_rs1_data = d1;
    id_rs2 = rs2; id_use_rs2 = u2; id_rs2_data = d2;
    id_imm = imm; id_src1_pc = s1pc; id_src2_imm = s2imm;
    id_funct_select = fs; id_reg_write = rw; id_is_load = ld;
  endtask

  // Queue the expected hazard for the current inputs and the outputs after the next edge.
  task automatic step(input logic eh, input out_t eo);
    rec_t r;
    r.h = eh;
    r.o = eo;
    exp_q.push_back(r);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    rec_t r;
    out_t act;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        checks++;
        if (hazard_stall !== r.h) begin
          errors++;
          $display("FAIL hazard_stall t=%0t got %0b want %0b", $time, hazard_stall, r.h);
        end
        @(posedge clk);
        #2;
        act = {ex_valid, ex_reg_write, ex_is_load, ex_rd, ex_pc, alu_in1, alu_in2,
               funct_select, ex_store_data};
        checks++;
        if (act !== r.o) begin
          errors++;
          $display("FAIL ex_outputs t=%0t got v%0b rw%0b ld%0b rd%0d pc%h a1 %h a2 %h fs%h sd %h want v%0b rw%0b ld%0b rd%0d pc%h a1 %h a2 %h fs%h sd %h",
                   $time, act.v, act.rw, act.ld, act.rd, act.pc, act.a1, act.a2, act.fs, act.sd,
                   r.o.v, r.o.rw, r.o.ld, r.o.rd, r.o.pc, r.o.a1, r.o.a2, r.o.fs, r.o.sd);
        end
      end
    end
  end

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: simulation did not complete, %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b1;
    idle();
    step(1'b0, BUB);
    step(1'b0, BUB);
    rst = 1'b0;

    // x0 writer with a nonzero result must never reach a reader of x0
    idle(); set_id(32'h100, 5'd0, 5'd0, 1, 0, 5'd0, 0, 0, 32'hFFFF, 0, 1, 5'd0, 1, 0);
    step(1'b0, mk(1, 1, 0, 5'd0, 32'h100, 0, 32'hFFFF, 5'd0, 0));
    idle(); ex_result = 32'hFFFF;
    mem_valid = 1; mem_reg_write = 1; mem_rd = 5'd0; mem_result = 32'hBEEF;
    set_id(32'h104, 5'd1, 5'd0, 1, 0, 5'd0, 1, 0, 0, 0, 0, 5'd0, 1, 0);
    step(1'b0, mk(1, 1, 0, 5'd1, 32'h104, 0, 0, 5'd0, 0));

    // downstream stall holds outputs while ID changes
    idle(); set_id(32'h108, 5'd2, 5'd0, 1, 0, 5'd0, 0, 0, 32'd5, 0, 1, 5'd0, 1, 0);
    step(1'b0, mk(1, 1, 0, 5'd2, 32'h108, 0, 5, 5'd0, 0));
    for (int i = 0; i < 3; i++) begin
      idle(); stall_in = 1;
      set_id(32'h10C, 5'd3, 5'd0, 1, 0, 5'd0, 0, 0, 32'(7 + i), 0, 1, 5'd0, 1, 0);
      step(1'b0, mk(1, 1, 0, 5'd2, 32'h108, 0, 5, 5'd0, 0));
    end
    idle(); set_id(32'h10C, 5'd3, 5'd0, 1, 0, 5'd0, 0, 0, 32'd7, 0, 1, 5'd0, 1, 0);
    step(1'b0, mk(1, 1, 0, 5'd3, 32'h10C, 0, 7, 5'd0, 0));

    // flush kills a valid instruction
    idle(); flush = 1; set_id(32'h110, 5'd4, 5'd0, 1, 0, 5'd0, 0, 0, 32'd9, 0, 1, 5'd0, 1, 0);
    step(1'b0, BUB);
    idle();
    step(1'b0, BUB);

    // PC and immediate operand sources
    idle(); set_id(32'h118, 5'd9, 5'd0, 0, 0, 5'd0, 0, 0, 32'h1000, 1, 1, 5'd0, 1, 0);
    step(1'b0, mk(1, 1, 0, 5'd9, 32'h118, 32'h118, 32'h1000, 5'd0, 0));

    // reset while a load-use hazard is pending
    idle(); set_id(32'h200, 5'd7, 5'd0, 1, 0, 5'd0, 0, 0, 0, 0, 1, 5'd0, 1, 1);
    step(1'b0, mk(1, 1, 1, 5'd7, 32'h200, 0, 0, 5'd0, 0));
    idle(); rst = 1; set_id(32'h204, 5'd8, 5'd7, 1, 32'h77, 5'd0, 0, 0, 32'd4, 0, 1, 5'd0, 1, 0);
    step(1'b1, BUB);
    rst = 0;
    idle(); set_id(32'h204, 5'd8, 5'd7, 1, 32'h77, 5'd0, 0, 0, 32'd4, 0, 1, 5'd0, 1, 0);
    step(1'b0, mk(1, 1, 0, 5'd8, 32'h204, 32'h77, 4, 5'd0, 0));
    idle();
    step(1'b0, BUB);

`ifdef EX_OPERAND_FWD_EN
    // ADD x5 then SUB x6,x5,x5 forwarded from EX
    idle(); set_id(32'h300, 5'd5, 5'd1, 1, 32'd8, 5'd2, 1, 32'd8, 0, 0, 0, 5'd0, 1, 0);
    step(1'b0, mk(1, 1, 0, 5'd5, 32'h300, 8, 8, 5'd0, 8));
    idle(); ex_result = 32'h10;
    set_id(32'h304, 5'd6, 5'd5, 1, 32'hAAAA, 5'd5, 1, 32'hAAAA, 0, 0, 0, 5'h10, 1, 0);
    step(1'b0, mk(1, 1, 0, 5'd6, 32'h304, 32'h10, 32'h10, 5'h10, 32'h10));
    // LW x7 then ADDI x8,x7,4: one bubble, then MEM forwarding
    idle(); set_id(32'h308, 5'd7, 5'd0, 1, 0, 5'd0, 0, 0, 0, 0, 1, 5'd0, 1, 1);
    step(1'b0, mk(1, 1, 1, 5'd7, 32'h308, 0, 0, 5'd0, 0));
    idle(); set_id(32'h30C, 5'd8, 5'd7, 1, 32'h1111, 5'd0, 0, 0, 32'd4, 0, 1, 5'd0, 1, 0);
    step(1'b1, BUB);
    idle(); mem_valid = 1; mem_reg_write = 1; mem_rd = 5'd7; mem_result = 32'hDEAD;
    set_id(32'h30C, 5'd8, 5'd7, 1, 32'h1111, 5'd0, 0, 0, 32'd4, 0, 1, 5'd0, 1, 0);
    step(1'b0, mk(1, 1, 0, 5'd8, 32'h30C, 32'hDEAD, 4, 5'd0, 0));
    // MEM beats WB
    idle(); ex_result = 32'h5;
    mem_valid = 1; mem_reg_write = 1; mem_rd = 5'd9; mem_result = 32'h1;
    wb_valid = 1; wb_reg_write = 1; wb_rd = 5'd9; wb_result = 32'h2;
    set_id(32'h310, 5'd10, 5'd9, 1, 32'h3, 5'd0, 0, 0, 0, 0, 1, 5'd0, 1, 0);
    step(1'b0, mk(1, 1, 0, 5'd10, 32'h310, 1, 0, 5'd0, 0));
    // EX beats MEM on rs2, reaching both alu_in2 and store data
    idle(); ex_result = 32'h55;
    mem_valid = 1; mem_reg_write = 1; mem_rd = 5'd10; mem_result = 32'h66;
    set_id(32'h314, 5'd11, 5'd0, 1, 0, 5'd10, 1, 32'h3, 0, 0, 0, 5'd0, 1, 0);
    step(1'b0, mk(1, 1, 0, 5'd11, 32'h314, 0, 32'h55, 5'd0, 32'h55));
    idle();
    step(1'b0, BUB);
`else
    // ADD x5 then ADD x6,x5,x0: three bubbles while x5 drains through EX, MEM, WB
    idle(); set_id(32'h300, 5'd5, 5'd1, 1, 32'd8, 5'd2, 1, 32'd8, 0, 0, 0, 5'd0, 1, 0);
    step(1'b0, mk(1, 1, 0, 5'd5, 32'h300, 8, 8, 5'd0, 8));
    idle(); ex_result = 32'h10;
    set_id(32'h304, 5'd6, 5'd5, 1, 32'h42, 5'd0, 1, 0, 0, 0, 0, 5'd0, 1, 0);
    step(1'b1, BUB);
    idle(); mem_valid = 1; mem_reg_write = 1; mem_rd = 5'd5; mem_result = 32'h10;
    set_id(32'h304, 5'd6, 5'd5, 1, 32'h42, 5'd0, 1, 0, 0, 0, 0, 5'd0, 1, 0);
    step(1'b1, BUB);
    idle(); wb_valid = 1; wb_reg_write = 1; wb_rd = 5'd5; wb_result = 32'h10;
    set_id(32'h304, 5'd6, 5'd5, 1, 32'h42, 5'd0, 1, 0, 0, 0, 0, 5'd0, 1, 0);
    step(1'b1, BUB);
    idle(); set_id(32'h304, 5'd6, 5'd5, 1, 32'h42, 5'd0, 1, 0, 0, 0, 0, 5'd0, 1, 0);
    step(1'b0, mk(1, 1, 0, 5'd6, 32'h304, 32'h42, 0, 5'd0, 0));
    // MEM-only writer of rs2 stalls; operand then comes from the register file
    idle(); mem_valid = 1; mem_reg_write = 1; mem_rd = 5'd9; mem_result = 32'h5;
    set_id(32'h308, 5'd10, 5'd0, 1, 0, 5'd9, 1, 32'h99, 0, 0, 0, 5'd0, 1, 0);
    step(1'b1, BUB);
    idle(); set_id(32'h308, 5'd10, 5'd0, 1, 0, 5'd9, 1, 32'h99, 0, 0, 0, 5'd0, 1, 0);
    step(1'b0, mk(1, 1, 0, 5'd10, 32'h308, 0, 32'h99, 5'd0, 32'h99));
    // a matching but unused rs2 does not stall
    idle(); set_id(32'h30C, 5'd11, 5'd0, 1, 0, 5'd10, 0, 32'h7, 32'd3, 0, 1, 5'd0, 1, 0);
    step(1'b0, mk(1, 1, 0, 5'd11, 32'h30C, 0, 3, 5'd0, 32'h7));
    idle();
    step(1'b0, BUB);
`endif

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX boundary register for the RV32I core: captures a decoded instruction, resolves its ALU operands, and presents `alu_in1`, `alu_in2` and `funct_select` to the execute-stage ALU one cycle later. Forwards results from the EX, MEM and WB stages, detects load-use hazards, and inserts bubbles. It also honours downstream stall and branch/jump flush requests.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `REG_AW`, 5, register index width

Ports (reset is one clock; synchronous, active-high):
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous active-high reset
- `id_valid`  in  1  decode slot holds an instruction
- `id_pc`  in  32  instruction PC
- `id_rs1`, `id_rs2`, `id_rd`  in  5 each  register indices
- `id_use_rs1`, `id_use_rs2`  in  1 each  instruction reads the register
- `id_rs1_data`, `id_rs2_data`  in  32 each  register-file read data (not write-through)
- `id_imm`  in  32  sign-extended immediate
- `id_src1_pc`  in  1  operand 1 = PC instead of rs1
- `id_src2_imm`  in  1  operand 2 = immediate instead of rs2
- `id_funct_select`  in  5  ALU function; bit 4 = subtract
- `id_reg_write`, `id_is_load`  in  1 each  writeback / load flags
- `ex_result`  in  32  ALU output of the instruction currently held here
- `mem_valid`, `mem_reg_write`  in  1 each; `mem_rd` in 5; `mem_result` in 32  MEM-stage writer
- `wb_valid`, `wb_reg_write`  in  1 each; `wb_rd` in 5; `wb_result` in 32  WB-stage writer
- `stall_in`  in  1  downstream freeze; hold all outputs
- `flush`  in  1  kill the instruction being captured
- `hazard_stall`  out  1  combinational; upstream must hold the ID slot
- `ex_valid`, `ex_reg_write`, `ex_is_load`  out  1 each
- `ex_rd`  out  5; `ex_pc`  out  32
- `alu_in1`, `alu_in2`  out  32; `funct_select`  out  5
- `ex_store_data`  out  32  forwarded rs2 value, for stores and branches

## Operation
- Forwarded rs value, priority high→low:
  1. EX: `ex_valid & ex_reg_write & !ex_is_load & ex_rd==rs` → `ex_result`
  2. MEM: `mem_valid & mem_reg_write & mem_rd==rs` → `mem_result`
  3. WB: `wb_valid & wb_reg_write & wb_rd==rs` → `wb_result`
  4. otherwise → `id_rsN_data`
- rs==0 never matches a forwarding source; the value is forced to 0.
- `alu_in1` = `id_src1_pc ? id_pc : fwd_rs1`. `alu_in2` = `id_src2_imm ? id_imm : fwd_rs2`. `ex_store_data` = `fwd_rs2` always.
- Load-use hazard: `hazard_stall` = `id_valid & ex_valid & ex_is_load & ex_rd!=0 & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2))`.
- Register update priority each edge:
  1. `rst`: all outputs 0.
  2. `stall_in`: hold all registers.
  3. `flush` or `hazard_stall`: capture a bubble (`ex_valid`, `ex_reg_write`, `ex_is_load` = 0; data fields don't-care, implementation clears them).
  4. Otherwise: capture the ID fields; `ex_valid` = `id_valid`.
- `funct_select` passes through unmodified. A bubble carries `funct_select`=0 (ADD).

## Timing
- Latency 1 cycle from ID inputs to EX outputs. No combinational path from ID inputs to EX outputs.
- `hazard_stall` is combinational from the current EX registers and ID inputs. It is asserted for exactly one cycle per load-use pair; after the bubble, forwarding comes from MEM.
- `hazard_stall` may be high while `stall_in` is high; the register holds and the hazard re-evaluates next cycle.
- Reset mid-stall or mid-hazard: outputs are 0 on the next edge, and `hazard_stall` drops because `ex_valid`=0.
- `flush` and `hazard_stall` together produce a single bubble.

## Configuration
- `EX_OPERAND_FWD_EN` defined: forwarding as above.
- `EX_OPERAND_FWD_EN` undefined:
  - all forwarding muxes are removed; operands come from `id_rsN_data` only.
  - `hazard_stall` asserts whenever any valid writer in EX (load or not), MEM or WB has a nonzero rd matching a used rs.
  - stalls persist until the writer retires; repeated bubbles are inserted.

## Test plan
- Back-to-back `ADD x5` (`ex_result`=0x10) then `SUB x6,x5,x5` → next cycle `alu_in1`=`alu_in2`=0x10, `funct_select`=0x10, no stall.
- `LW x7` in EX, `ADDI x8,x7,4` in ID → `hazard_stall`=1 for 1 cycle. Then a bubble (`ex_valid`=0). Then `alu_in1`=`mem_result` (0xDEAD), `alu_in2`=4.
- MEM and WB both write x9 (0x1 / 0x2), ID reads x9 → `alu_in1`=0x1, so MEM wins.
- Writer targets x0 with `ex_result`=0xFFFF, ID reads x0 → `alu_in1`=0, no stall.
- `stall_in`=1 for 3 cycles with new ID data → outputs unchanged. `flush` with `id_valid`=1 → `ex_valid`=0. `rst` during the hazard → all outputs 0.
- Without `EX_OPERAND_FWD_EN`: `ADD x5` then dependent `ADD x6,x5,x0` → 3 bubbles, then `alu_in1` = regfile data.
